// File: rtl/string_hw_arbiter.sv
// Round-robin sequencer that shares one String_HW accelerator between NUM_REQ requesters.
// Commands arrive over valid/ready. Responses return per requester with a status code.
module string_hw_arbiter #(
    parameter int MAX_BLOCKS = 8,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     cmd_valid,
    output logic [NUM_REQ-1:0]                     cmd_ready,
    input  logic [NUM_REQ-1:0][3:0]                cmd_index,
    input  logic [NUM_REQ-1:0][7:0]                cmd_length,
    input  logic [NUM_REQ-1:0][MAX_BLOCKS*32-1:0]  cmd_A,
    input  logic [NUM_REQ-1:0][MAX_BLOCKS*32-1:0]  cmd_B,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    input  logic [NUM_REQ-1:0]                     rsp_ready,
    output logic [1:0]                             rsp_status,
    output logic [MAX_BLOCKS*32-1:0]               rsp_result,
    output logic                                   acc_go,
    output logic [3:0]                             acc_index,
    output logic [7:0]                             acc_length,
    output logic [MAX_BLOCKS*32-1:0]               acc_A,
    output logic [MAX_BLOCKS*32-1:0]               acc_B,
    input  logic                                   acc_done,
    input  logic [MAX_BLOCKS*32-1:0]               acc_result,
    output logic                                   busy
);

    localparam int DW = MAX_BLOCKS * 32;
    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BAD     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [3:0] MAX_OPCODE = 4'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] grant;
    logic [TW-1:0] timer;
    logic          rel_wait;
    logic          late_done_seen;
    logic [GW:0]   pick_vec;
    logic [GW-1:0] pick_idx;
    logic          pick_found;

    // First valid requester at or after ptr, searching with wrap-around; MSB flags a hit.
    function automatic logic [GW:0] pick(input logic [NUM_REQ-1:0] valid,
                                         input logic [GW-1:0]      ptr);
        logic [GW:0] res;
        int          k;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!res[GW] && valid[k]) begin
                res = {1'b1, GW'(k)};
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
        logic [NUM_REQ-1:0] res;
        res      = '0;
        res[idx] = 1'b1;
        return res;
    endfunction

    // Arbitration result and the combinational accept strobe offered only while idle.
    always_comb begin
        pick_vec   = pick(cmd_valid, rr_ptr);
        pick_idx   = pick_vec[GW-1:0];
        pick_found = pick_vec[GW];
        if (state == IDLE && pick_found && !reset) begin
            cmd_ready = onehot(pick_idx);
        end else begin
            cmd_ready = '0;
        end
    end

    // Sequencer FSM; every output except cmd_ready is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant          <= '0;
            timer          <= '0;
            rel_wait       <= 1'b0;
            late_done_seen <= 1'b0;
            rsp_valid      <= '0;
            rsp_status     <= ST_OK;
            rsp_result     <= '0;
            acc_go         <= 1'b0;
            acc_index      <= 4'd0;
            acc_length     <= 8'd0;
            acc_A          <= '0;
            acc_B          <= '0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        busy  <= 1'b1;
                        if (cmd_index[pick_idx] > MAX_OPCODE) begin
                            // Illegal opcode never reaches the accelerator.
                            rsp_status <= ST_BAD;
                            rsp_result <= '0;
                            rsp_valid  <= onehot(pick_idx);
                            state      <= RESPOND;
                        end else begin
                            acc_index  <= cmd_index[pick_idx];
                            acc_length <= cmd_length[pick_idx];
                            acc_A      <= cmd_A[pick_idx];
                            acc_B      <= cmd_B[pick_idx];
                            acc_go     <= 1'b1;
                            timer      <= '0;
                            state      <= ISSUE;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (acc_done) begin
                        rsp_result     <= acc_result;
                        rsp_status     <= ST_OK;
                        acc_go         <= 1'b0;
                        rel_wait       <= 1'b0;
                        late_done_seen <= 1'b0;
                        state          <= RELEASE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_result     <= '0;
                        rsp_status     <= ST_TIMEOUT;
                        acc_go         <= 1'b0;
                        rel_wait       <= 1'b0;
                        late_done_seen <= 1'b0;
                        state          <= RELEASE;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end else begin
                        timer <= timer;
                    end
                end
                RELEASE: begin
                    if (rsp_status == ST_TIMEOUT) begin
                        // A hung accelerator may still raise done late: wait it out, else give it two cycles.
                        if (acc_done) begin
                            late_done_seen <= 1'b1;
                        end else if (late_done_seen || rel_wait) begin
                            rsp_valid <= onehot(grant);
                            state     <= RESPOND;
                        end else begin
                            rel_wait <= 1'b1;
                        end
                    end else if (!acc_done) begin
                        rsp_valid <= onehot(grant);
                        state     <= RESPOND;
                    end else begin
                        state <= RELEASE;
                    end
                end
                RESPOND: begin
                    if (rsp_ready[grant]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                        if (grant == GW'(NUM_REQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= grant + GW'(1);
                        end
                    end else begin
                        state <= RESPOND;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc_go    <= 1'b0;
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_string_hw_arbiter.sv
// Directed bench for string_hw_arbiter with a behavioural String_HW model
// (upper, lower, search) that can be made to hang.
module tb_string_hw_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DW      = 256;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQ-1:0]          cmd_valid;
    logic [NUM_REQ-1:0]          cmd_ready;
    logic [NUM_REQ-1:0][3:0]     cmd_index;
    logic [NUM_REQ-1:0][7:0]     cmd_length;
    logic [NUM_REQ-1:0][DW-1:0]  cmd_A;
    logic [NUM_REQ-1:0][DW-1:0]  cmd_B;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [NUM_REQ-1:0]          rsp_ready;
    logic [1:0]                  rsp_status;
    logic [DW-1:0]               rsp_result;
    logic                        acc_go;
    logic [3:0]                  acc_index;
    logic [7:0]                  acc_length;
    logic [DW-1:0]               acc_A;
    logic [DW-1:0]               acc_B;
    logic                        acc_done = 1'b0;
    logic [DW-1:0]               acc_result = '0;
    logic                        busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit hang     = 1'b0;
    int lat_cnt  = 0;
    int go_rises = 0;
    logic go_prev = 1'b0;
    int g0;

    string_hw_arbiter #(.MAX_BLOCKS(8), .NUM_REQ(NUM_REQ), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
        .cmd_length(cmd_length), .cmd_A(cmd_A), .cmd_B(cmd_B),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_result(rsp_result), .acc_go(acc_go), .acc_index(acc_index),
        .acc_length(acc_length), .acc_A(acc_A), .acc_B(acc_B),
        .acc_done(acc_done), .acc_result(acc_result), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] s2v(input string s);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v[i*8 +: 8] = s[i];
        return v;
    endfunction

    function automatic logic [1:0] oh(input int req);
        logic [1:0] v;
        v = 2'b00;
        v[req] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] acc_model(input logic [3:0] op, input logic [7:0] len,
                                                input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        bit            match;
        r = a;
        case (op)
            4'd1: for (int i = 0; i < 32; i++)
                      if (a[i*8 +: 8] >= 8'h61 && a[i*8 +: 8] <= 8'h7a) r[i*8 +: 8] = a[i*8 +: 8] - 8'h20;
            4'd2: for (int i = 0; i < 32; i++)
                      if (a[i*8 +: 8] >= 8'h41 && a[i*8 +: 8] <= 8'h5a) r[i*8 +: 8] = a[i*8 +: 8] + 8'h20;
            4'd4: begin
                r = '1;
                for (int p = 31; p >= 0; p--) begin
                    match = 1'b1;
                    for (int j = 0; j < int'(len); j++) begin
                        if (p + j > 31) match = 1'b0;
                        else if (a[(p+j)*8 +: 8] != b[j*8 +: 8]) match = 1'b0;
                    end
                    if (match) r = DW'(p);
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Accelerator model: done (with result) two cycles into go, held until go drops.
    always @(posedge clk) begin
        if (acc_go && !hang) begin
            if (lat_cnt >= 2) begin
                acc_done   <= 1'b1;
                acc_result <= acc_model(acc_index, acc_length, acc_A, acc_B);
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            acc_done <= 1'b0;
            lat_cnt  <= 0;
        end
    end

    // Count go pulses handed to the accelerator.
    always @(posedge clk) begin
        go_prev <= acc_go;
        if (acc_go && !go_prev) go_rises <= go_rises + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input int req, input logic [3:0] op, input logic [7:0] len,
                             input string a, input string b);
        cmd_index[req]  = op;
        cmd_length[req] = len;
        cmd_A[req]      = s2v(a);
        cmd_B[req]      = s2v(b);
        cmd_valid[req]  = 1'b1;
    endtask

    task automatic issue(input int req, input logic [3:0] op, input logic [7:0] len,
                         input string a, input string b, input string tag);
        @(negedge clk);
        drive_cmd(req, op, len, a, b);
        #1 check({tag, "_ready"}, DW'(cmd_ready), DW'(oh(req)));
        @(negedge clk);
        cmd_valid[req] = 1'b0;
    endtask

    task automatic wait_valid(input int req);
        int n;
        n = 0;
        while (!rsp_valid[req] && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rsp(input int req, input logic [1:0] st, input logic [DW-1:0] res,
                            input string tag);
        wait_valid(req);
        check({tag, "_valid"}, DW'(rsp_valid), DW'(oh(req)));
        check({tag, "_status"}, DW'(rsp_status), DW'(st));
        check({tag, "_result"}, rsp_result, res);
        rsp_ready[req] = 1'b1;
        @(negedge clk);
        rsp_ready[req] = 1'b0;
        check({tag, "_valid_clr"}, DW'(rsp_valid), '0);
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = '0;
        cmd_index  = '0;
        cmd_length = '0;
        cmd_A      = '0;
        cmd_B      = '0;
        rsp_ready  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", DW'(cmd_ready), '0);
        check("rst_rsp_valid", DW'(rsp_valid), '0);
        check("rst_busy", DW'(busy), '0);
        check("rst_go", DW'(acc_go), '0);
        check("rst_status", DW'(rsp_status), '0);
        check("rst_result", rsp_result, '0);
        check("rst_acc_A", acc_A, '0);
        reset = 1'b0;

        // 1) upper-case on requester 0
        g0 = go_rises;
        issue(0, 4'd1, 8'd0, "hello", "", "t1");
        wait_rsp(0, 2'd0, s2v("HELLO"), "t1");
        check("t1_go_pulses", DW'(go_rises), DW'(g0 + 1));
        check("t1_busy", DW'(busy), '0);

        // 3) illegal opcode on requester 1: response the cycle after accept
        g0 = go_rises;
        @(negedge clk);
        drive_cmd(1, 4'd7, 8'd0, "zz", "");
        #1 check("t3_ready", DW'(cmd_ready), DW'(2'b10));
        @(posedge clk);
        #1;
        check("t3_rsp_valid", DW'(rsp_valid), DW'(2'b10));
        check("t3_go", DW'(acc_go), '0);
        check("t3_acc_index", DW'(acc_index), DW'(4'd1));
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        wait_rsp(1, 2'd1, '0, "t3");
        check("t3_go_pulses", DW'(go_rises), DW'(g0));

        // 2) simultaneous requests with rr pointer back at 0, then fairness
        @(negedge clk);
        drive_cmd(0, 4'd2, 8'd0, "ABC", "");
        drive_cmd(1, 4'd1, 8'd0, "xyz", "");
        #1 check("t2_ready_first", DW'(cmd_ready), DW'(2'b01));
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check("t2_ready_busy", DW'(cmd_ready), '0);
        wait_rsp(0, 2'd0, s2v("abc"), "t2a");
        drive_cmd(0, 4'd1, 8'd0, "q", "");
        #1 check("t2_ready_fair", DW'(cmd_ready), DW'(2'b10));
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        wait_rsp(1, 2'd0, s2v("XYZ"), "t2b");
        #1 check("t2_ready_third", DW'(cmd_ready), DW'(2'b01));
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        wait_rsp(0, 2'd0, s2v("Q"), "t2c");

        // 4) accelerator hangs: timeout 64 cycles after go
        hang = 1'b1;
        @(negedge clk);
        drive_cmd(1, 4'd1, 8'd0, "abc", "");
        #1 check("t4_ready", DW'(cmd_ready), DW'(2'b10));
        @(posedge clk);
        #1;
        check("t4_go_on", DW'(acc_go), DW'(1'b1));
        cmd_valid[1] = 1'b0;
        repeat (63) @(posedge clk);
        #1 check("t4_go_held", DW'(acc_go), DW'(1'b1));
        @(posedge clk);
        #1;
        check("t4_go_off", DW'(acc_go), '0);
        check("t4_status", DW'(rsp_status), DW'(2'd2));
        @(posedge clk);
        #1 check("t4_release1", DW'(rsp_valid), '0);
        @(posedge clk);
        #1 check("t4_respond", DW'(rsp_valid), DW'(2'b10));
        hang = 1'b0;
        @(negedge clk);
        wait_rsp(1, 2'd2, '0, "t4");

        // 5) search, response held while rsp_ready stays low
        issue(0, 4'd4, 8'd3, "xxabcx", "abc", "t5");
        wait_valid(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_hold_valid", DW'(rsp_valid), DW'(2'b01));
            check("t5_hold_result", rsp_result, DW'(2));
            rsp_ready[1] = 1'b1;
        end
        rsp_ready[1] = 1'b0;
        wait_rsp(0, 2'd0, DW'(2), "t5");

        // 6) reset while ISSUE is waiting on a hung accelerator
        hang = 1'b1;
        issue(1, 4'd1, 8'd0, "abc", "", "t6");
        repeat (3) @(negedge clk);
        check("t6_go_before", DW'(acc_go), DW'(1'b1));
        #2 reset = 1'b1;
        #1;
        check("t6_go_async", DW'(acc_go), '0);
        check("t6_busy_async", DW'(busy), '0);
        check("t6_rsp_async", DW'(rsp_valid), '0);
        @(negedge clk);
        reset = 1'b0;
        hang  = 1'b0;
        issue(1, 4'd1, 8'd0, "abc", "", "t6b");
        wait_rsp(1, 2'd0, s2v("ABC"), "t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
